pipe_stage_regs: RTL

Pipeline state holder for the five-stage RV32I core: the PC register, the Fetch→Decode register and the Decode→Execute register. It consumes the stall and flush commands produced by the hazard unit (StallF, StallD, FlushD, FlushE), so it is the receiving end of that control interface. It also exports per-stage valid bits and, optionally, performance counters that account for every stalled, flushed and bubbled cycle.

---
 rtl/pipe_stage_regs.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/pipe_stage_regs.sv
// Pipeline state for the five-stage RV32I core: PC, F->D and D->E registers.
// Optional performance counters are enabled by defining PERF_CNT_EN.
module pipe_stage_regs #(
  parameter int unsigned            XLEN     = 32,
  parameter logic [XLEN-1:0]        RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      StallF,
  input  logic                      StallD,
  input  logic                      FlushD,
  input  logic                      FlushE,
  input  logic [XLEN-1:0]           PCNextF,
  output logic [XLEN-1:0]           PCF,
  input  logic [31:0]               InstrF,
  input  logic [XLEN-1:0]           PCPlus4F,
  output logic [31:0]               InstrD,
  output logic [XLEN-1:0]           PCD,
  output logic [XLEN-1:0]           PCPlus4D,
  output logic                      ValidD,
  input  logic                      RegWriteD,
  input  logic                      MemWriteD,
  input  logic                      JumpD,
  input  logic                      BranchD,
  input  logic                      ALUSrcD,
  input  logic [1:0]                ResultSrcD,
  input  logic [2:0]                ALUControlD,
  input  logic [XLEN-1:0]           RD1D,
  input  logic [XLEN-1:0]           RD2D,
  input  logic [XLEN-1:0]           ImmExtD,
  input  logic [XLEN-1:0]           PCD_in,
  input  logic [XLEN-1:0]           PCPlus4D_in,
  input  logic [4:0]                Rs1D,
  input  logic [4:0]                Rs2D,
  input  logic [4:0]                RdD,
  output logic                      RegWriteE,
  output logic                      MemWriteE,
  output logic                      JumpE,
  output logic                      BranchE,
  output logic                      ALUSrcE,
  output logic [1:0]                ResultSrcE,
  output logic [2:0]                ALUControlE,
  output logic [XLEN-1:0]           RD1E,
  output logic [XLEN-1:0]           RD2E,
  output logic [XLEN-1:0]           ImmExtE,
  output logic [XLEN-1:0]           PCE,
  output logic [XLEN-1:0]           PCPlus4E,
  output logic [4:0]                Rs1E,
  output logic [4:0]                Rs2E,
  output logic [4:0]                RdE,
`ifdef PERF_CNT_EN
  output logic                      ValidE,
  output logic [31:0]               CycleCnt,
  output logic [31:0]               StallCnt,
  output logic [31:0]               FlushCnt,
  output logic [31:0]               BubbleCnt
`else
  output logic                      ValidE
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic            reg_write;
    logic            mem_write;
    logic            jump;
    logic            branch;
    logic            alu_src;
    logic [1:0]      result_src;
    logic [2:0]      alu_control;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            valid;
  } de_t;

  logic [XLEN-1:0] r_pcf;
  logic [31:0]     r_instr_d;
  logic [XLEN-1:0] r_pc_d;
  logic [XLEN-1:0] r_pc_plus4_d;
  logic            r_valid_d;
  de_t             r_de;
  de_t             w_de_next;

  // PC register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pcf <= RESET_PC;
    end else if (!StallF) begin
      r_pcf <= PCNextF;
    end
  end

  // F->D register: flush beats stall so a redirect never keeps a stale slot
  always_ff @(posedge clk) begin
    if (reset || FlushD) begin
      r_instr_d    <= NOP;
      r_pc_d       <= '0;
      r_pc_plus4_d <= '0;
      r_valid_d    <= 1'b0;
    end else if (!StallD) begin
      r_instr_d    <= InstrF;
      r_pc_d       <= r_pcf;
      r_pc_plus4_d <= PCPlus4F;
      r_valid_d    <= 1'b1;
    end
  end

  always_comb begin
    w_de_next             = '0;
    w_de_next.reg_write   = RegWriteD;
    w_de_next.mem_write   = MemWriteD;
    w_de_next.jump        = JumpD;
    w_de_next.branch      = BranchD;
    w_de_next.alu_src     = ALUSrcD;
    w_de_next.result_src  = ResultSrcD;
    w_de_next.alu_control = ALUControlD;
    w_de_next.rd1         = RD1D;
    w_de_next.rd2         = RD2D;
    w_de_next.imm_ext     = ImmExtD;
    w_de_next.pc          = PCD_in;
    w_de_next.pc_plus4    = PCPlus4D_in;
    w_de_next.rs1         = Rs1D;
    w_de_next.rs2         = Rs2D;
    w_de_next.rd          = RdD;
    w_de_next.valid       = r_valid_d;
  end

  // D->E register: a bubble is all-zero so it can never write or match a forward compare
  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      r_de <= '0;
    end else begin
      r_de <= w_de_next;
    end
  end

  assign PCF         = r_pcf;
  assign InstrD      = r_instr_d;
  assign PCD         = r_pc_d;
  assign PCPlus4D    = r_pc_plus4_d;
  assign ValidD      = r_valid_d;
  assign RegWriteE   = r_de.reg_write;
  assign MemWriteE   = r_de.mem_write;
  assign JumpE       = r_de.jump;
  assign BranchE     = r_de.branch;
  assign ALUSrcE     = r_de.alu_src;
  assign ResultSrcE  = r_de.result_src;
  assign ALUControlE = r_de.alu_control;
  assign RD1E        = r_de.rd1;
  assign RD2E        = r_de.rd2;
  assign ImmExtE     = r_de.imm_ext;
  assign PCE         = r_de.pc;
  assign PCPlus4E    = r_de.pc_plus4;
  assign Rs1E        = r_de.rs1;
  assign Rs2E        = r_de.rs2;
  assign RdE         = r_de.rd;
  assign ValidE      = r_de.valid;

`ifdef PERF_CNT_EN
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;
  logic [31:0] r_bubble_cnt;
  logic        w_bubble;

  // ValidE loads 0 on a flush or when D is empty; both together count once
  assign w_bubble = FlushE || !r_valid_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle_cnt  <= '0;
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (StallD)   r_stall_cnt  <= r_stall_cnt + 32'd1;
      if (FlushD)   r_flush_cnt  <= r_flush_cnt + 32'd1;
      if (w_bubble) r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign CycleCnt  = r_cycle_cnt;
  assign StallCnt  = r_stall_cnt;
  assign FlushCnt  = r_flush_cnt;
  assign BubbleCnt = r_bubble_cnt;
`endif

endmodule
